// File: rtl/spi_msg_ctrl.sv
// SPI slave receive sequencer: arms the shifter, gathers a
// fixed-length message and hands it over via valid/ack.
module spi_msg_ctrl #(
  parameter int MSG_BYTES   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic                           ready,
  input  logic [7:0]                     rx_byte,
  input  logic                           rx_valid,
  output logic                           start,
  output logic                           busy,
  output logic [$clog2(MSG_BYTES+1)-1:0] byte_cnt,
  output logic [8*MSG_BYTES-1:0]         msg_data,
  output logic                           msg_valid,
  input  logic                           msg_ack,
  output logic                           err_abort,
  output logic                           err_timeout,
  output logic                           err_overrun
);

  localparam int CW = $clog2(MSG_BYTES+1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_HOLD,
    S_WAIT
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [8*MSG_BYTES-1:0] data_q, data_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   start_q, start_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic                   abort_q, abort_d;
  logic                   tmo_q, tmo_d;
  logic                   ovr_q, ovr_d;

  logic [8*MSG_BYTES-1:0] data_ins;
  logic                   last_byte;

  // buffer with rx_byte dropped into the slot at the current count
  always_comb begin
    data_ins = data_q;
    for (int k = 0; k < MSG_BYTES; k++) begin
      if (cnt_q == CW'(k)) data_ins[8*k +: 8] = rx_byte;
    end
  end

  assign last_byte = rx_valid && (cnt_q == CW'(MSG_BYTES-1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    timer_d = timer_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    tmo_d   = 1'b0;
    ovr_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ready) begin
          state_d = S_RECV;
          start_d = 1'b1;
          cnt_d   = '0;
          data_d  = '0;
          timer_d = '0;
        end
      end
      S_RECV: begin
        if (last_byte) begin
          data_d  = data_ins;
          cnt_d   = CW'(MSG_BYTES);
          state_d = S_HOLD;
        end else if (!ready) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
          cnt_d   = '0;
        end else if (rx_valid) begin
          data_d  = data_ins;
          cnt_d   = cnt_q + 1'b1;
          timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT_CYC-1)) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_HOLD: begin
        ovr_d = rx_valid;
        if (msg_ack) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      timer_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign start       = start_q;
  assign busy        = busy_q;
  assign byte_cnt    = cnt_q;
  assign msg_data    = data_q;
  assign msg_valid   = valid_q;
  assign err_abort   = abort_q;
  assign err_timeout = tmo_q;
  assign err_overrun = ovr_q;

endmodule

// File: tb/tb_spi_msg_ctrl.sv
// Bench for spi_msg_ctrl: directed scenarios plus a random run
// against a transaction-level model of the receive sequencer.
module tb_spi_msg_ctrl;

  localparam int MB = 4;
  localparam int TO = 16;
  localparam int CW = $clog2(MB+1);

  logic          clk = 1'b0;
  logic          rst_l = 1'b1;
  logic          ready = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_valid = 1'b0;
  logic          msg_ack = 1'b0;
  logic          start, busy, msg_valid;
  logic          err_abort, err_timeout, err_overrun;
  logic [CW-1:0] byte_cnt;
  logic [8*MB-1:0] msg_data;

  int checks = 0;
  int errors = 0;

  spi_msg_ctrl #(.MSG_BYTES(MB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_l(rst_l), .ready(ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .start(start), .busy(busy), .byte_cnt(byte_cnt),
    .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_ack(msg_ack), .err_abort(err_abort),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // model: phase 0 idle, 1 collecting, 2 holding, 3 awaiting release
  int         ph;
  int         quiet;
  logic [7:0] got[$];
  logic [CW-1:0] m_cnt;
  bit m_start, m_abort, m_tmo, m_ovr;

  function automatic void model_reset();
    ph = 0;
    quiet = 0;
    got.delete();
    m_cnt = '0;
    m_start = 0; m_abort = 0; m_tmo = 0; m_ovr = 0;
  endfunction

  function automatic logic [8*MB-1:0] exp_data();
    logic [8*MB-1:0] d = '0;
    foreach (got[k]) d[8*k +: 8] = got[k];
    return d;
  endfunction

  function automatic void model_step();
    m_start = 0; m_abort = 0; m_tmo = 0; m_ovr = 0;
    case (ph)
      0: if (ready) begin
        m_start = 1; ph = 1; got.delete(); m_cnt = '0; quiet = 0;
      end
      1: begin
        if (rx_valid && got.size() == MB-1) begin
          got.push_back(rx_byte); m_cnt = CW'(MB); ph = 2;
        end else if (!ready) begin
          m_abort = 1; ph = 0; m_cnt = '0;
        end else if (rx_valid) begin
          got.push_back(rx_byte); m_cnt = CW'(got.size()); quiet = 0;
        end else if (quiet == TO-1) begin
          m_tmo = 1; ph = 0; m_cnt = '0;
        end else begin
          quiet++;
        end
      end
      2: begin
        if (rx_valid) m_ovr = 1;
        if (msg_ack) ph = 3;
      end
      default: if (!ready) ph = 0;
    endcase
  endfunction

  task automatic step();
    if (!rst_l) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_l = 1'b0;
    ready = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      rx_valid = i[0];
      rx_byte = 8'h5A;
      step();
      checks++;
      if ({start, busy, byte_cnt, msg_valid, err_abort, err_timeout,
           err_overrun} !== '0 || msg_data !== '0) begin
        errors++;
        $display("FAIL reset_hold: st=%b bz=%b cnt=%0d v=%b d=%h want all 0",
                 start, busy, byte_cnt, msg_valid, msg_data);
      end
    end
    ready = 1'b0;
    rx_valid = 1'b0;
    rst_l = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || start !== 1'b0) begin
        errors++;
        $display("FAIL reset_release: busy=%b start=%b want 0 0", busy, start);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] b[4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    ready = 1'b1;
    step();
    checks++;
    if (start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: start=%b busy=%b want 1 1", start, busy);
    end
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_byte = b[i];
      step();
      checks++;
      if (byte_cnt !== CW'(i+1) || start !== 1'b0 ||
          msg_valid !== (i == 3)) begin
        errors++;
        $display("FAIL basic_cnt%0d: cnt=%0d start=%b valid=%b want %0d 0 %b",
                 i, byte_cnt, start, msg_valid, i+1, i == 3);
      end
    end
    rx_valid = 1'b0;
    checks++;
    if (msg_data !== 32'h01FF3CA5) begin
      errors++;
      $display("FAIL basic_data: got %h want 01ff3ca5", msg_data);
    end
    msg_ack = 1'b1;
    step();
    msg_ack = 1'b0;
    checks++;
    if (msg_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_ack: valid=%b busy=%b want 0 1", msg_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (busy !== 1'b1 || start !== 1'b0) begin
        errors++;
        $display("FAIL basic_wait: busy=%b start=%b want 1 0", busy, start);
      end
    end
    ready = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: busy=%b want 0", busy);
    end
  endtask

  task automatic test_abort();
    ready = 1'b1;
    step();
    rx_valid = 1'b1;
    rx_byte = 8'h11;
    step();
    rx_byte = 8'h22;
    step();
    rx_valid = 1'b0;
    checks++;
    if (byte_cnt !== CW'(2)) begin
      errors++;
      $display("FAIL abort_cnt: got %0d want 2", byte_cnt);
    end
    ready = 1'b0;
    step();
    checks++;
    if (err_abort !== 1'b1 || byte_cnt !== '0 || busy !== 1'b0 ||
        msg_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse: ab=%b cnt=%0d busy=%b v=%b want 1 0 0 0",
               err_abort, byte_cnt, busy, msg_valid);
    end
    step();
    checks++;
    if (err_abort !== 1'b0 || msg_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_once: ab=%b v=%b want 0 0", err_abort, msg_valid);
    end
    ready = 1'b1;
    step();
    checks++;
    if (start !== 1'b1) begin
      errors++;
      $display("FAIL abort_rearm: start=%b want 1", start);
    end
    ready = 1'b0;
    step();
    step();
  endtask

  task automatic test_timeout();
    ready = 1'b1;
    step();
    for (int i = 0; i < TO-1; i++) begin
      step();
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL timeout_early%0d: tmo=%b busy=%b want 0 1",
                 i, err_timeout, busy);
      end
    end
    step();
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || start !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: tmo=%b busy=%b start=%b want 1 0 0",
               err_timeout, busy, start);
    end
    step();
    checks++;
    if (start !== 1'b1 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rearm: start=%b tmo=%b want 1 0",
               start, err_timeout);
    end
    ready = 1'b0;
    step();
    step();
  endtask

  task automatic test_overrun();
    logic [31:0] want = '0;
    ready = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      rx_valid = 1'b1;
      rx_byte = 8'($urandom);
      want[8*k +: 8] = rx_byte;
      step();
    end
    rx_valid = 1'b1;
    rx_byte = 8'hEE;
    step();
    rx_valid = 1'b0;
    checks++;
    if (err_overrun !== 1'b1 || msg_data !== want || msg_valid !== 1'b1 ||
        byte_cnt !== CW'(4)) begin
      errors++;
      $display("FAIL overrun: ovr=%b d=%h v=%b cnt=%0d want 1 %h 1 4",
               err_overrun, msg_data, msg_valid, byte_cnt, want);
    end
    step();
    checks++;
    if (err_overrun !== 1'b0 || msg_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_once: ovr=%b v=%b want 0 1",
               err_overrun, msg_valid);
    end
    msg_ack = 1'b1;
    step();
    msg_ack = 1'b0;
    ready = 1'b0;
    step();
    ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      rx_valid = 1'b1;
      rx_byte = 8'(8'h10 * (k + 1));
      step();
    end
    rx_byte = 8'h40;
    ready = 1'b0;
    step();
    rx_valid = 1'b0;
    checks++;
    if (msg_valid !== 1'b1 || err_abort !== 1'b0 ||
        msg_data !== 32'h40302010) begin
      errors++;
      $display("FAIL final_vs_drop: v=%b ab=%b d=%h want 1 0 40302010",
               msg_valid, err_abort, msg_data);
    end
    step();
    checks++;
    if (msg_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_ignores_ready: v=%b busy=%b want 1 1",
               msg_valid, busy);
    end
    msg_ack = 1'b1;
    step();
    msg_ack = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || msg_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: busy=%b v=%b want 0 0", busy, msg_valid);
    end
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    step();
    rx_valid = 1'b1;
    rx_byte = 8'h77;
    step();
    rx_valid = 1'b0;
    #2 rst_l = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({start, busy, byte_cnt, msg_valid, err_abort, err_timeout,
         err_overrun} !== '0 || msg_data !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b cnt=%0d d=%h want all 0",
               busy, byte_cnt, msg_data);
    end
    step();
    rst_l = 1'b1;
    step();
    checks++;
    if (start !== 1'b1 || byte_cnt !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_restart: start=%b cnt=%0d busy=%b want 1 0 1",
               start, byte_cnt, busy);
    end
  endtask

  task automatic test_random();
    int div;
    for (int i = 0; i < 4000; i++) begin
      case ((i / 500) % 4)
        0: div = 2;
        1: div = 4;
        2: div = 40;
        default: div = 64;
      endcase
      if ($urandom_range(0, 19) == 0) ready = ~ready;
      rx_valid = ($urandom_range(0, div - 1) == 0);
      rx_byte = 8'($urandom);
      msg_ack = ($urandom_range(0, 3) == 0);
      step();
      checks++;
      if ({start, busy, byte_cnt, msg_valid, err_abort, err_timeout,
           err_overrun} !== {m_start, ph != 0, m_cnt, ph == 2, m_abort,
           m_tmo, m_ovr} || msg_data !== exp_data()) begin
        errors++;
        if (errors < 20)
          $display("FAIL random@%0d: st%b bz%b c%0d v%b e%b%b%b d%h want st%b bz%b c%0d v%b e%b%b%b d%h",
                   i, start, busy, byte_cnt, msg_valid, err_abort,
                   err_timeout, err_overrun, msg_data, m_start, ph != 0,
                   m_cnt, ph == 2, m_abort, m_tmo, m_ovr, exp_data());
      end
    end
    rx_valid = 1'b0;
    msg_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_abort();
    test_timeout();
    test_overrun();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_msg_ctrl.md
Name: spi_msg_ctrl

Overview:
Transaction sequencer for the FPGA SPI slave receive path. It detects a master request and arms the byte shifter with a one-cycle start pulse. It then collects MSG_BYTES received bytes into a message buffer and presents the completed message to the consumer through a valid/ack handshake. It also detects aborted, stalled and overrun transactions, and waits for the master to release the request before it re-arms.

Parameters:
MSG_BYTES  4     bytes per message; legal range 1..16
TIMEOUT_CYC  1024  consecutive RECV cycles without rx_valid before abort; legal range 2..65535

Ports:
clk  input  1  system clock, rising edge
rst_l  input  1  reset, asynchronous, active-low
ready  input  1  master request level (synchronised chip-select / ready from master)
rx_byte  input  8  byte from SPI shifter, valid when rx_valid=1
rx_valid  input  1  single-cycle strobe from shifter, one per received byte
start  output  1  one-cycle pulse arming the shifter
busy  output  1  high whenever state != IDLE
byte_cnt  output  $clog2(MSG_BYTES+1)  bytes stored in current message
msg_data  output  8*MSG_BYTES  message; byte k at bits [8k+7:8k], byte 0 = first received
msg_valid  output  1  message complete and stable
msg_ack  input  1  consumer accepts message
err_abort  output  1  one-cycle pulse: ready dropped mid-message
err_timeout  output  1  one-cycle pulse: shifter stalled TIMEOUT_CYC cycles
err_overrun  output  1  one-cycle pulse: rx_valid while message held

Behaviour:
- Reset (rst_l=0, asynchronous, takes effect without a clock edge): state=IDLE. All outputs are 0: start, busy, byte_cnt, msg_data, msg_valid, err_*. Internal timer = 0.
- All outputs are registered. States are IDLE, RECV, HOLD and WAIT_REL.
- IDLE:
  - On a clock edge with ready=1: start=1 for exactly the next cycle, state goes to RECV, byte_cnt=0, msg_data cleared to 0, timer=0.
  - rx_valid is ignored in IDLE.
- RECV, evaluated each edge in priority order:
  1. rx_valid=1 and byte_cnt==MSG_BYTES-1: store rx_byte at index byte_cnt, byte_cnt=MSG_BYTES, go to HOLD, msg_valid=1 from the next cycle. This applies even if ready=0 in the same cycle.
  2. ready=0: go to IDLE, err_abort pulse, byte_cnt=0. A coincident non-final byte is discarded. msg_data keeps its partial contents; it is not valid.
  3. rx_valid=1: store rx_byte at index byte_cnt, increment byte_cnt, timer=0.
  4. timer==TIMEOUT_CYC-1: go to IDLE, err_timeout pulse, byte_cnt=0.
  5. Otherwise timer increments.
  - Timer width is $clog2(TIMEOUT_CYC); it never wraps.
  - The timeout fires on the TIMEOUT_CYC-th consecutive cycle without rx_valid, counted from the first cycle in RECV.
- HOLD:
  - msg_valid=1; msg_data and byte_cnt are stable.
  - rx_valid produces an err_overrun pulse. The byte is dropped and the buffer is unchanged.
  - On msg_ack=1: msg_valid=0 next cycle and state goes to WAIT_REL.
  - ready is ignored in HOLD. The message is never discarded without ack.
- WAIT_REL:
  - Go to IDLE on the first edge with ready=0. While ready=1, remain (no re-arm on the same request).
  - The minimum dwell is one cycle.
  - rx_valid in WAIT_REL is ignored with no error.
- start is never asserted outside the IDLE->RECV transition. There is at most one start per ready assertion.
- err_* pulses last exactly one cycle and are mutually exclusive in a given cycle.
- msg_ack outside HOLD is ignored.
- Reset mid-operation discards any partial or held message. After reset is released with ready=1, a new start is issued on the first edge.

Test Plan:
1. Hold rst_l=0, drive ready=1 and rx_valid toggling -> all outputs 0. Release with ready=0 -> busy=0, no start.
2. MSG_BYTES=4: raise ready; after start, strobe A5,3C,FF,01 ->
   - byte_cnt steps 1..4;
   - msg_valid=1 one cycle after the 4th strobe;
   - msg_data=32'h01FF3CA5.
   Then pulse msg_ack -> msg_valid=0 next cycle; busy stays 1 until ready=0, then IDLE.
3. Strobe 2 bytes, then drop ready -> err_abort single pulse, byte_cnt=0, msg_valid never asserts. Re-raise ready -> a new start pulse.
4. TIMEOUT_CYC=16: raise ready with no rx_valid -> err_timeout pulses on the 16th RECV cycle, state goes to IDLE. With ready still high -> start re-issues next cycle.
5. In HOLD, strobe rx_valid with 8'hEE -> err_overrun pulse, msg_data unchanged. Final byte coincident with ready=0 -> message completes, no err_abort.
6. Assert rst_l=0 asynchronously mid-RECV after 1 byte -> outputs clear before the next edge. Release with ready=1 -> start on the first edge, byte_cnt=0.
